// File: rtl/riscv_tag_exc_ctrl.sv
// rtl/riscv_tag_exc_ctrl.sv - DIFT tag-check violation controller with trap handshake
module riscv_tag_exc_ctrl #(
    parameter int NUM_SRC   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dift_en_i,
    input  logic [NUM_SRC-1:0]         src_exc_i,
    input  logic [31:0]                src_pc_i,
    output logic                       exc_req_o,
    input  logic                       exc_ack_i,
    output logic [$clog2(NUM_SRC)-1:0] exc_cause_o,
    output logic [31:0]                exc_pc_o,
    output logic                       status_valid_o,
    output logic                       missed_o,
    input  logic                       clear_i,
    output logic [CNT_WIDTH-1:0]       viol_cnt_o
);

    localparam int CW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              hit;
    logic [CW-1:0]     sel;
    logic              capture;
    logic              valid_nxt;
    logic              missed_nxt;

    assign hit = dift_en_i & (|src_exc_i);

    // Lowest asserted index wins; scan downward so the last assignment is the lowest.
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_exc_i[i]) begin
                sel = CW'(i);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        valid_nxt  = status_valid_o;
        missed_nxt = missed_o;
        case (state)
            IDLE: begin
                if (clear_i) begin
                    missed_nxt = 1'b0;
                end
                if (hit) begin
                    capture   = 1'b1;
                    valid_nxt = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (hit) begin
                    missed_nxt = 1'b1;
                end
                if (exc_ack_i) begin
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (clear_i) begin
                    // Clear takes effect first, so a same-cycle hit starts a fresh capture.
                    valid_nxt  = 1'b0;
                    missed_nxt = 1'b0;
                    state_nxt  = IDLE;
                    if (hit) begin
                        capture   = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = REQ;
                    end
                end else if (hit) begin
                    missed_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            exc_req_o      <= 1'b0;
            exc_cause_o    <= '0;
            exc_pc_o       <= '0;
            status_valid_o <= 1'b0;
            missed_o       <= 1'b0;
        end else begin
            state          <= state_nxt;
            exc_req_o      <= (state_nxt == REQ);
            status_valid_o <= valid_nxt;
            missed_o       <= missed_nxt;
            if (capture) begin
                exc_cause_o <= sel;
                exc_pc_o    <= src_pc_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            viol_cnt_o <= '0;
        end else if (hit && (viol_cnt_o != {CNT_WIDTH{1'b1}})) begin
            viol_cnt_o <= viol_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_tag_exc_ctrl.sv
// tb/tb_riscv_tag_exc_ctrl.sv - self-checking bench for riscv_tag_exc_ctrl
module tb_riscv_tag_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dift_en;
    logic [3:0]  src_exc;
    logic [31:0] src_pc;
    logic        exc_ack;
    logic        clear;

    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        status_valid;
    logic        missed;
    logic [15:0] viol_cnt;

    logic        s_exc_req;
    logic [1:0]  s_exc_cause;
    logic [31:0] s_exc_pc;
    logic        s_status_valid;
    logic        s_missed;
    logic [1:0]  s_viol_cnt;

    always #5 clk = ~clk;

    riscv_tag_exc_ctrl #(.NUM_SRC(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .dift_en_i(dift_en), .src_exc_i(src_exc),
        .src_pc_i(src_pc), .exc_req_o(exc_req), .exc_ack_i(exc_ack),
        .exc_cause_o(exc_cause), .exc_pc_o(exc_pc), .status_valid_o(status_valid),
        .missed_o(missed), .clear_i(clear), .viol_cnt_o(viol_cnt)
    );

    riscv_tag_exc_ctrl #(.NUM_SRC(4), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .dift_en_i(dift_en), .src_exc_i(src_exc),
        .src_pc_i(src_pc), .exc_req_o(s_exc_req), .exc_ack_i(exc_ack),
        .exc_cause_o(s_exc_cause), .exc_pc_o(s_exc_pc), .status_valid_o(s_status_valid),
        .missed_o(s_missed), .clear_i(clear), .viol_cnt_o(s_viol_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference: "trap outstanding" and "trap accepted" flags plus the captured record.
    bit          m_outstanding;
    bit          m_accepted;
    bit          m_valid;
    bit          m_missed;
    int          m_cause;
    logic [31:0] m_pc;
    longint      m_hits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit hit;
        int sel;
        hit = dift_en && (src_exc != 4'd0);
        sel = -1;
        for (int i = 0; i < 4; i++) begin
            if (src_exc[i] && sel < 0) sel = i;
        end
        if (!rst_n) begin
            m_outstanding = 0; m_accepted = 0; m_valid = 0; m_missed = 0;
            m_cause = 0; m_pc = '0; m_hits = 0;
            return;
        end
        if (hit) m_hits++;
        if (!m_outstanding) begin
            if (clear) m_missed = 0;
            if (hit) begin
                m_outstanding = 1; m_accepted = 0; m_valid = 1;
                m_cause = sel; m_pc = src_pc;
            end
        end else if (!m_accepted) begin
            if (hit) m_missed = 1;
            if (exc_ack) m_accepted = 1;
        end else if (clear) begin
            m_valid = 0; m_missed = 0; m_outstanding = 0;
            if (hit) begin
                m_outstanding = 1; m_accepted = 0; m_valid = 1;
                m_cause = sel; m_pc = src_pc;
            end
        end else if (hit) begin
            m_missed = 1;
        end
    endtask

    task automatic check_all();
        longint big_max;
        longint small_max;
        big_max   = (m_hits > 65535) ? 65535 : m_hits;
        small_max = (m_hits > 3) ? 3 : m_hits;
        chk("req",    32'(exc_req),      32'(m_outstanding && !m_accepted));
        chk("cause",  32'(exc_cause),    32'(m_cause));
        chk("pc",     exc_pc,            m_pc);
        chk("valid",  32'(status_valid), 32'(m_valid));
        chk("missed", 32'(missed),       32'(m_missed));
        chk("cnt",    32'(viol_cnt),     32'(big_max));
        chk("cnt_w2", 32'(s_viol_cnt),   32'(small_max));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic quiet();
        src_exc = 4'd0; exc_ack = 1'b0; clear = 1'b0; dift_en = 1'b1; src_pc = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; src_exc = 4'hF;
        tick(); tick();
        rst_n = 1'b1; quiet();
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();

        // 1: reset while every source fires
        do_reset();
        chk("rst_cnt", 32'(viol_cnt), 32'd0);
        chk("rst_req", 32'(exc_req), 32'd0);
        tick();

        // 2: single hit, delayed ack, clear
        src_exc = 4'b0100; src_pc = 32'h100;
        tick();
        quiet();
        chk("t2_req", 32'(exc_req), 32'd1);
        chk("t2_cause", 32'(exc_cause), 32'd2);
        chk("t2_pc", exc_pc, 32'h100);
        chk("t2_cnt", 32'(viol_cnt), 32'd1);
        tick(); tick();
        exc_ack = 1'b1; tick(); exc_ack = 1'b0;
        chk("t2_req_drop", 32'(exc_req), 32'd0);
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t2_clear", 32'(status_valid), 32'd0);

        // 3: priority between simultaneous sources
        do_reset();
        src_exc = 4'b1010; src_pc = 32'h200;
        tick();
        quiet();
        chk("t3_cause", 32'(exc_cause), 32'd1);
        chk("t3_missed", 32'(missed), 32'd0);
        chk("t3_cnt", 32'(viol_cnt), 32'd1);

        // 4: lost event while request pending
        src_exc = 4'b0001; src_pc = 32'h300;
        tick();
        quiet();
        chk("t4_cause", 32'(exc_cause), 32'd1);
        chk("t4_pc", exc_pc, 32'h200);
        chk("t4_missed", 32'(missed), 32'd1);
        chk("t4_cnt", 32'(viol_cnt), 32'd2);
        exc_ack = 1'b1; tick(); exc_ack = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4_clear", 32'(missed), 32'd0);

        // 5: clear and hit together in HELD
        src_exc = 4'b0001; src_pc = 32'h3C0; tick(); quiet();
        exc_ack = 1'b1; tick(); exc_ack = 1'b0;
        clear = 1'b1; src_exc = 4'b1000; src_pc = 32'h400;
        tick();
        quiet();
        chk("t5_req", 32'(exc_req), 32'd1);
        chk("t5_cause", 32'(exc_cause), 32'd3);
        chk("t5_pc", exc_pc, 32'h400);
        chk("t5_valid", 32'(status_valid), 32'd1);

        // 6: masking, narrow counter saturation, reset mid-request
        exc_ack = 1'b1; tick(); exc_ack = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        dift_en = 1'b0; src_exc = 4'hF;
        tick(); tick();
        chk("t6_mask_req", 32'(exc_req), 32'd0);
        quiet();
        do_reset();
        src_exc = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        quiet();
        chk("t6_sat", 32'(s_viol_cnt), 32'd3);
        chk("t6_req_before_rst", 32'(exc_req), 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t6_rst_req", 32'(exc_req), 32'd0);

        // randomized traffic against the reference
        for (int n = 0; n < 800; n++) begin
            rst_n   = ($urandom % 80) != 0;
            dift_en = ($urandom % 8) != 0;
            src_exc = (($urandom % 3) == 0) ? 4'($urandom) : 4'd0;
            src_pc  = $urandom;
            exc_ack = ($urandom % 3) == 0;
            clear   = ($urandom % 4) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
